// File: rtl/systolic_operand_feeder.sv
// Operand feeder for the FP8 E4M3 systolic PE array.
// Holds an NxK tile of A and a KxN tile of B, loaded one byte at a time.
// On start it issues a one-cycle accumulator clear, then streams A into the
// west edge and B into the north edge with a diagonal skew. Lanes outside
// the skew window carry 0x00. It pulses done once the last PE has consumed
// its final operand pair.
module systolic_operand_feeder #(
  parameter int N = 2,
  parameter int K = 2
) (
  input  logic           clk,
  input  logic           rst,
  input  logic           load_en,
  input  logic           load_sel,
  input  logic [7:0]     load_data,
  input  logic           start,
  output logic           busy,
  output logic           clear_out,
  output logic [8*N-1:0] a_row,
  output logic [8*N-1:0] b_col,
  output logic           done
);

  localparam int DEPTH = N * K;
  localparam int AW    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
  localparam int CW    = $clog2(K + 2 * N + 1);

  localparam logic [AW-1:0] PTR_LAST    = AW'(DEPTH - 1);
  localparam logic [CW-1:0] STREAM_LAST = CW'(K + N - 2);
  localparam logic [CW-1:0] FLUSH_LAST  = CW'(K + 2 * N - 3);

  typedef enum logic [2:0] {
    IDLE,
    CLEAR,
    STREAM,
    FLUSH,
    DONE
  } state_t;

  state_t          state_q, state_d;
  logic [CW-1:0]   cnt_q, cnt_d;
  logic [AW-1:0]   aPtr_q, bPtr_q;
  logic [7:0]      aMem [DEPTH];
  logic [7:0]      bMem [DEPTH];
  logic            wrEn;
  logic            runStart;

  logic            busy_q, clear_q, done_q;
  logic [8*N-1:0]  aRow_q, aRow_d;
  logic [8*N-1:0]  bCol_q, bCol_d;
  int              tCur;
  int              kIdx;

  // Writes are only accepted while idle; a write alongside start still lands.
  assign wrEn     = (state_q == IDLE) && load_en;
  assign runStart = (state_q == IDLE) && start;

  // Sequencer: the shared counter runs continuously through STREAM and FLUSH
  // so it always equals the global skew cycle t.
  always_comb begin
    state_d = state_q;
    cnt_d   = cnt_q;
    unique case (state_q)
      IDLE: begin
        if (start) begin
          state_d = CLEAR;
          cnt_d   = '0;
        end
      end
      CLEAR: begin
        state_d = STREAM;
        cnt_d   = '0;
      end
      STREAM: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == STREAM_LAST) begin
          state_d = (N == 1) ? DONE : FLUSH;
        end
      end
      FLUSH: begin
        cnt_d = cnt_q + 1'b1;
        if (cnt_q == FLUSH_LAST) begin
          state_d = DONE;
        end
      end
      DONE: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
      default: begin
        state_d = IDLE;
        cnt_d   = '0;
      end
    endcase
  end

  // State and skew-counter registers.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q <= IDLE;
      cnt_q   <= '0;
    end else begin
      state_q <= state_d;
      cnt_q   <= cnt_d;
    end
  end

  // Write pointers: advance per accepted byte, and rewind when a run starts
  // so the next tile loads from element 0.
  always_ff @(posedge clk) begin
    if (rst) begin
      aPtr_q <= '0;
      bPtr_q <= '0;
    end else if (runStart) begin
      aPtr_q <= '0;
      bPtr_q <= '0;
    end else if (wrEn) begin
      if (load_sel) begin
        bPtr_q <= (bPtr_q == PTR_LAST) ? '0 : bPtr_q + 1'b1;
      end else begin
        aPtr_q <= (aPtr_q == PTR_LAST) ? '0 : aPtr_q + 1'b1;
      end
    end
  end

  // Tile buffers; contents survive reset and runs so a tile can be re-streamed.
  always_ff @(posedge clk) begin
    if (wrEn && !rst) begin
      if (load_sel) begin
        bMem[bPtr_q] <= load_data;
      end else begin
        aMem[aPtr_q] <= load_data;
      end
    end
  end

  // Operands for the upcoming cycle: row i takes A[i][t-i], column j takes
  // B[t-j][j], zero outside the skew window or outside STREAM.
  always_comb begin
    aRow_d = '0;
    bCol_d = '0;
    tCur   = 0;
    kIdx   = 0;
    if (state_d == STREAM) begin
      tCur = int'(cnt_d);
      for (int i = 0; i < N; i++) begin
        kIdx = tCur - i;
        if (kIdx >= 0 && kIdx < K) begin
          aRow_d[8*i +: 8] = aMem[AW'(i * K + kIdx)];
        end
      end
      for (int j = 0; j < N; j++) begin
        kIdx = tCur - j;
        if (kIdx >= 0 && kIdx < K) begin
          bCol_d[8*j +: 8] = bMem[AW'(kIdx * N + j)];
        end
      end
    end
  end

  // All outputs come from flops so the array sees glitch-free edges.
  always_ff @(posedge clk) begin
    if (rst) begin
      busy_q  <= 1'b0;
      clear_q <= 1'b0;
      done_q  <= 1'b0;
      aRow_q  <= '0;
      bCol_q  <= '0;
    end else begin
      busy_q  <= (state_d != IDLE);
      clear_q <= (state_d == CLEAR);
      done_q  <= (state_d == DONE);
      aRow_q  <= aRow_d;
      bCol_q  <= bCol_d;
    end
  end

  assign busy      = busy_q;
  assign clear_out = clear_q;
  assign done      = done_q;
  assign a_row     = aRow_q;
  assign b_col     = bCol_q;

endmodule

// File: tb/tb_systolic_operand_feeder.sv
// Scoreboard bench for systolic_operand_feeder with N = K = 2.
// The driver queues the hand-computed per-cycle outputs of each run. The monitor
// pops one entry for every busy cycle. It checks that outputs are quiet while idle.
module tb_systolic_operand_feeder;

  localparam int N = 2;
  localparam int K = 2;

  logic           clk = 1'b0;
  logic           rst;
  logic           load_en;
  logic           load_sel;
  logic [7:0]     load_data;
  logic           start;
  logic           busy;
  logic           clear_out;
  logic [8*N-1:0] a_row;
  logic [8*N-1:0] b_col;
  logic           done;

  typedef struct packed {
    logic        clr;
    logic        dn;
    logic [15:0] a;
    logic [15:0] b;
  } exp_t;

  exp_t expQ[$];
  int   checks    = 0;
  int   errors    = 0;
  int   doneCount = 0;
  bit   monitorEn = 1'b0;

  systolic_operand_feeder #(.N(N), .K(K)) dut (
    .clk       (clk),
    .rst       (rst),
    .load_en   (load_en),
    .load_sel  (load_sel),
    .load_data (load_data),
    .start     (start),
    .busy      (busy),
    .clear_out (clear_out),
    .a_row     (a_row),
    .b_col     (b_col),
    .done      (done)
  );

  // Free-running clock.
  always #5 clk = ~clk;

  task automatic checkOutput(input string name, input logic [39:0] actual,
                             input logic [39:0] expected);
    checks++;
    if (actual !== expected) begin
      errors++;
      $display("[TB] FAIL %s actual=%h required=%h", name, actual, expected);
    end
  endtask

  // Drive one cycle of inputs just after the rising edge.
  task automatic applyStimulus(input logic le, input logic sel,
                               input logic [7:0] data, input logic st);
    @(posedge clk);
    #1;
    load_en   = le;
    load_sel  = sel;
    load_data = data;
    start     = st;
  endtask

  task automatic loadTile(input logic [7:0] a0, input logic [7:0] a1,
                          input logic [7:0] a2, input logic [7:0] a3,
                          input logic [7:0] b0, input logic [7:0] b1,
                          input logic [7:0] b2, input logic [7:0] b3);
    applyStimulus(1'b1, 1'b0, a0, 1'b0);
    applyStimulus(1'b1, 1'b0, a1, 1'b0);
    applyStimulus(1'b1, 1'b0, a2, 1'b0);
    applyStimulus(1'b1, 1'b0, a3, 1'b0);
    applyStimulus(1'b1, 1'b1, b0, 1'b0);
    applyStimulus(1'b1, 1'b1, b1, 1'b0);
    applyStimulus(1'b1, 1'b1, b2, 1'b0);
    applyStimulus(1'b1, 1'b1, b3, 1'b0);
  endtask

  // Queue CLEAR, three STREAM cycles, FLUSH and DONE for one full run.
  task automatic pushRun(input logic [15:0] a0, input logic [15:0] a1,
                         input logic [15:0] a2, input logic [15:0] b0,
                         input logic [15:0] b1, input logic [15:0] b2);
    expQ.push_back('{clr: 1'b1, dn: 1'b0, a: 16'h0000, b: 16'h0000});
    expQ.push_back('{clr: 1'b0, dn: 1'b0, a: a0, b: b0});
    expQ.push_back('{clr: 1'b0, dn: 1'b0, a: a1, b: b1});
    expQ.push_back('{clr: 1'b0, dn: 1'b0, a: a2, b: b2});
    expQ.push_back('{clr: 1'b0, dn: 1'b0, a: 16'h0000, b: 16'h0000});
    expQ.push_back('{clr: 1'b0, dn: 1'b1, a: 16'h0000, b: 16'h0000});
  endtask

  task automatic pushOriginal();
    pushRun(16'h0038, 16'h0000, 16'h3800, 16'h0040, 16'h4430, 16'hB800);
  endtask

  task automatic waitIdle(input string name);
    for (int c = 0; c < 50; c++) begin
      @(posedge clk);
      #1;
      if (busy === 1'b0) return;
    end
    checks++;
    errors++;
    $display("[TB] FAIL %s timeout actual=busy required=idle", name);
  endtask

  // Monitor: every busy cycle consumes one expected entry; idle cycles must be quiet.
  always @(negedge clk) begin
    exp_t e;
    if (monitorEn) begin
      if (done === 1'b1) doneCount++;
      if (busy === 1'b1) begin
        if (expQ.size() == 0) begin
          checks++;
          errors++;
          $display("[TB] FAIL unexpected_busy actual=busy required=idle");
        end else begin
          e = expQ.pop_front();
          checkOutput("busy_cycle", {6'd0, clear_out, done, a_row, b_col},
                      {6'd0, e.clr, e.dn, e.a, e.b});
        end
      end else if (busy === 1'b0) begin
        checkOutput("idle_outputs", {6'd0, clear_out, done, a_row, b_col}, 40'd0);
      end else begin
        checkOutput("busy_known", {39'd0, busy}, 40'd0);
      end
    end
  end

  initial begin
    rst       = 1'b1;
    load_en   = 1'b0;
    load_sel  = 1'b0;
    load_data = 8'h00;
    start     = 1'b0;

    // Reset held for two edges with random load/start activity.
    repeat (2) begin
      @(posedge clk);
      #1;
      load_en   = 1'($urandom);
      load_sel  = 1'($urandom);
      load_data = 8'($urandom);
      start     = 1'($urandom);
      monitorEn = 1'b1;
    end
    @(posedge clk);
    #1;
    rst     = 1'b0;
    load_en = 1'b0;
    start   = 1'b0;
    checkOutput("reset_busy", {39'd0, busy}, 40'd0);

    // Run 1: skew pattern.
    loadTile(8'h38, 8'h00, 8'h00, 8'h38, 8'h40, 8'h44, 8'h30, 8'hB8);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    pushOriginal();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("run1");
    checkOutput("done_count_run1", 40'(doneCount), 40'd1);

    // Run 2: no reload; load_en and start hammered while busy.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    pushOriginal();
    applyStimulus(1'b1, 1'b0, 8'hFF, 1'b1);
    applyStimulus(1'b1, 1'b1, 8'hEE, 1'b1);
    applyStimulus(1'b1, 1'b0, 8'hDD, 1'b1);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("run2");
    checkOutput("done_count_run2", 40'(doneCount), 40'd2);

    // Run 3: re-stream shows the busy-time writes were discarded.
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    pushOriginal();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("run3");
    checkOutput("done_count_run3", 40'(doneCount), 40'd3);

    // Run 4: B = 01..04, five A writes; the fifth rides with start and overwrites A[0][0].
    applyStimulus(1'b1, 1'b1, 8'h01, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h02, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h03, 1'b0);
    applyStimulus(1'b1, 1'b1, 8'h04, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h11, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h22, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h33, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h44, 1'b0);
    applyStimulus(1'b1, 1'b0, 8'h55, 1'b1);
    pushRun(16'h0055, 16'h3322, 16'h4400, 16'h0001, 16'h0203, 16'h0400);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("run4_wrap");
    checkOutput("done_count_run4", 40'(doneCount), 40'd4);

    // Run 5: reset during STREAM t1 aborts with no done pulse.
    loadTile(8'h38, 8'h00, 8'h00, 8'h38, 8'h40, 8'h44, 8'h30, 8'hB8);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    expQ.push_back('{clr: 1'b1, dn: 1'b0, a: 16'h0000, b: 16'h0000});
    expQ.push_back('{clr: 1'b0, dn: 1'b0, a: 16'h0038, b: 16'h0040});
    expQ.push_back('{clr: 1'b0, dn: 1'b0, a: 16'h0000, b: 16'h4430});
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b1;
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    rst = 1'b0;
    checkOutput("abort_busy", {39'd0, busy}, 40'd0);
    repeat (8) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("done_count_abort", 40'(doneCount), 40'd4);
    checkOutput("abort_queue_drained", 40'(expQ.size()), 40'd0);

    // Run 6: a fresh load and start after the abort completes normally.
    loadTile(8'h38, 8'h00, 8'h00, 8'h38, 8'h40, 8'h44, 8'h30, 8'hB8);
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b1);
    pushOriginal();
    applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    waitIdle("run6");
    repeat (3) applyStimulus(1'b0, 1'b0, 8'h00, 1'b0);
    checkOutput("done_count_final", 40'(doneCount), 40'd5);
    checkOutput("queue_empty", 40'(expQ.size()), 40'd0);

    monitorEn = 1'b0;
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
